// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier controller.
package booth_pkg;

    // Default operand width, which is also the number of Booth iterations.
    localparam int BOOTH_WIDTH = 32;

    // Controller states, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Upper-half ALU operation codes. 2'b11 is reserved and never produced.
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Radix-2 Booth recoding of {Q[0], Q[-1]}.
    function automatic logic [1:0] booth_decode(input logic [1:0] bits);
        logic [1:0] op;
        case (bits)
            2'b01:   op = ALU_ADD;
            2'b10:   op = ALU_SUB;
            default: op = ALU_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Control bus between the Booth controller and its datapath.
interface booth_seq_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic [1:0]       booth_bits;
    logic             busy;
    logic             done;
    logic             rsa_en;
    logic             rsa_shift;
    logic             load_sel;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] iter;

    // Datapath / requester side.
    modport master (
        output start, booth_bits,
        input  busy, done, rsa_en, rsa_shift, load_sel, alu_op, iter
    );

    // Controller side.
    modport slave (
        input  start, booth_bits,
        output busy, done, rsa_en, rsa_shift, load_sel, alu_op, iter
    );
endinterface

// File: rtl/booth_seq_ctrl_iter_counter.sv
// Booth iteration counter with synchronous clear, increment and terminal count.
module iter_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    // Terminal count marks the last iteration (WIDTH-1).
    assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller. Moore outputs are
// registered from the next state so they settle right after the rising
// edge, well ahead of the falling edge on which the shift register samples.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    booth_seq_ctrl_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic             busy_q;
    logic             done_q;
    logic             rsa_en_q;
    logic             rsa_shift_q;
    logic             load_sel_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_ADD;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = cnt_tc ? ST_DONE : ST_ADD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter clears entering LOAD or IDLE, steps on each SHIFT->ADD loop-back,
    // and therefore holds its final value through DONE.
    assign cnt_clr = (state_d == ST_LOAD) || (state_d == ST_IDLE);
    assign cnt_inc = (state_q == ST_SHIFT) && (state_d == ST_ADD);

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // State register plus registered Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsa_en_q    <= 1'b0;
            rsa_shift_q <= 1'b0;
            load_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= state_d inside {ST_LOAD, ST_ADD, ST_SHIFT};
            done_q      <= (state_d == ST_DONE);
            rsa_en_q    <= state_d inside {ST_LOAD, ST_ADD, ST_SHIFT};
            rsa_shift_q <= (state_d == ST_SHIFT);
            load_sel_q  <= (state_d == ST_LOAD);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rsa_en    = rsa_en_q;
    assign bus.rsa_shift = rsa_shift_q;
    assign bus.load_sel  = load_sel_q;
    assign bus.iter      = cnt;
    // The only Mealy output: Booth recoding applies only during ADD.
    assign bus.alu_op    = (state_q == ST_ADD) ? booth_decode(bus.booth_bits) : ALU_PASS;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Testbench for booth_seq_ctrl with a behavioural Booth datapath and a
// product scoreboard.
module tb_booth_seq_ctrl;

    localparam int W  = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.CNT_W(CW)) bif ();

    booth_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Behavioural datapath: {guard, A[31:0], Q[31:0], Q[-1]}. The guard bit
    // keeps A's true sign when subtracting a multiplicand of -2^31.
    logic [W-1:0]   mcand  = '0;
    logic [W-1:0]   mplier = '0;
    logic [2*W+1:0] dp_q   = '0;
    logic           force_en  = 1'b0;
    logic [1:0]     force_val = 2'b00;

    assign bif.booth_bits = force_en ? force_val : dp_q[1:0];

    always @(negedge clk) begin
        if (bif.rsa_en) begin
            if (bif.load_sel)
                dp_q <= {{(W+1){1'b0}}, mplier, 1'b0};
            else if (bif.rsa_shift)
                dp_q <= {dp_q[2*W+1], dp_q[2*W+1:1]};
            else if (bif.alu_op == 2'b01)
                dp_q[2*W+1:W+1] <= dp_q[2*W+1:W+1] + {mcand[W-1], mcand};
            else if (bif.alu_op == 2'b10)
                dp_q[2*W+1:W+1] <= dp_q[2*W+1:W+1] - {mcand[W-1], mcand};
        end
    end

    // Global monitors.
    int done_cnt = 0;
    bit alu11_seen = 1'b0;
    always @(negedge clk) begin
        if (bif.done) done_cnt <= done_cnt + 1;
        if (bif.alu_op == 2'b11) alu11_seen <= 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [63:0] e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check(name, dp_q[2*W:1], e);
        end
    endtask

    // Expected {busy,done,rsa_en,rsa_shift,load_sel,iter} in cycle c after start.
    function automatic logic [10:0] exp_ctrl(input int c);
        if (c == 1)           return {5'b10101, 6'd0};
        else if (c == 2*W+2)  return {5'b01000, 6'(W-1)};
        else if (c % 2 == 0)  return {5'b10100, 6'((c-2)/2)};
        else                  return {5'b10110, 6'((c-3)/2)};
    endfunction

    function automatic logic [10:0] act_ctrl();
        return {bif.busy, bif.done, bif.rsa_en, bif.rsa_shift, bif.load_sel, bif.iter};
    endfunction

    function automatic logic [12:0] all_out();
        return {act_ctrl(), bif.alu_op};
    endfunction

    // One multiply: checks the per-cycle control trace, done latency, product,
    // and the return to IDLE. pulse_at=c pulses start during cycle c+1.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [63:0] exp, input bit use_sb,
                          input int pulse_at, input string tag,
                          output int n_alu);
        int  lat;
        int  bad;
        bit  got;
        logic [1:0] exp_alu;
        lat = 0; bad = 0; got = 1'b0; n_alu = 0;
        @(negedge clk);
        mcand = m; mplier = q; bif.start = 1'b1;
        if (use_sb) sb.push_back(exp);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c <= 2*W+2 && act_ctrl() !== exp_ctrl(c)) bad++;
            exp_alu = 2'b00;
            if (c >= 2 && c <= 2*W && c % 2 == 0) begin
                case (bif.booth_bits)
                    2'b01:   exp_alu = 2'b01;
                    2'b10:   exp_alu = 2'b10;
                    default: exp_alu = 2'b00;
                endcase
            end
            if (bif.alu_op !== exp_alu) bad++;
            if (bif.alu_op != 2'b00) n_alu++;
            if (bif.done) begin lat = c; got = 1'b1; break; end
            @(negedge clk);
            bif.start = (c == pulse_at);
        end
        check({tag, "_latency"}, 64'(lat), 64'(2*W+2));
        check({tag, "_trace"}, 64'(bad), 64'd0);
        if (use_sb) begin
            if (got) sb_check({tag, "_product"});
            else begin sb.delete(); check({tag, "_product_timeout"}, 64'd1, 64'd0); end
        end
        $display("op %s: 0x%08h * 0x%08h -> 0x%016h after %0d cycles", tag, m, q, dp_q[2*W:1], lat);
        @(negedge clk);
        bif.start = (pulse_at == 2*W+2);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, 64'(all_out()), 64'd0);
        @(negedge clk);
        bif.start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_still_idle"}, 64'(bif.busy), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [63:0]  p;
        string        name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n_alu;
        int nd, d1, d2, low;
        bit found;
        int snap;

        vecs[0] = '{32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "v1_7xm3"};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "v2_minxmin"};
        vecs[2] = '{32'd0,        32'hFFFF_FFFF, 64'd0,                   "v2_0xm1"};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                   "m1xm1"};
        vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "maxxmax"};
        vecs[5] = '{32'd12345,    -32'sd6789,    -64'sd83810205,          "mixed"};
        vecs[6] = '{32'd5,        32'd6,         64'd30,                  "5x6"};

        bif.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(all_out()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven products.
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].m, vecs[i].q, vecs[i].p, 1'b1, 0, vecs[i].name, n_alu);

        // Forced booth_bits: SUB in all 32 ADD cycles, then PASS throughout.
        force_en = 1'b1; force_val = 2'b10;
        run_op(32'd7, 32'd3, 64'd0, 1'b0, 0, "v3_force10", n_alu);
        check("v3_sub_cycles", 64'(n_alu), 64'd32);
        force_val = 2'b00;
        run_op(32'd7, 32'd3, 64'd0, 1'b0, 0, "v3_force00", n_alu);
        check("v3_pass_cycles", 64'(n_alu), 64'd0);
        force_en = 1'b0;

        // Mid-operation reset at iteration 10.
        @(negedge clk);
        mcand = 32'd9; mplier = 32'd9; bif.start = 1'b1;
        sb.push_back(64'd81);
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bif.iter == 6'd10 && bif.busy && !bif.rsa_shift) begin found = 1'b1; break; end
        end
        check("v4_reach_iter10", 64'(found), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        snap = done_cnt;
        @(posedge clk); #1;
        check("v4_abort_outputs", 64'(all_out()), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("v4_no_done_after_abort", 64'(done_cnt - snap), 64'd0);
        $display("op v4_abort: reset at iteration 10, done pulses after abort %0d", done_cnt - snap);

        // rst and start together: rst wins.
        @(negedge clk);
        rst = 1'b1; bif.start = 1'b1;
        @(posedge clk); #1;
        check("rst_wins", 64'(all_out()), 64'd0);
        @(negedge clk);
        rst = 1'b0; bif.start = 1'b0;
        @(posedge clk); #1;
        check("rst_wins_idle", 64'(bif.busy), 64'd0);
        run_op(32'd5, 32'd6, 64'd30, 1'b1, 0, "v4_fresh_5x6", n_alu);

        // Start held high for 200 cycles.
        @(negedge clk);
        mcand = 32'd3; mplier = 32'd4; bif.start = 1'b1;
        nd = 0; d1 = 0; d2 = 0; low = 0;
        for (int c = 1; c <= 199; c++) begin
            @(posedge clk); #1;
            if (bif.load_sel) sb.push_back(64'd12);
            if (bif.done) begin
                nd++;
                if (nd == 1) d1 = c;
                else if (nd == 2) d2 = c;
                sb_check("v5_product");
            end
            if (nd == 1 && !bif.busy) low++;
        end
        @(negedge clk);
        bif.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bif.done) begin found = 1'b1; sb_check("v5_drain_product"); break; end
        end
        check("v5_drain_done", 64'(found), 64'd1);
        check("v5_done_count", 64'(nd), 64'd2);
        check("v5_done_gap", 64'(d2 - d1), 64'd67);
        check("v5_busy_low", 64'(low), 64'd2);
        $display("op v5_held_start: dones %0d at %0d and %0d, busy-low %0d", nd, d1, d2, low);
        repeat (2) @(posedge clk);

        // Start pulse while busy, and start coinciding with DONE.
        run_op(32'd11, 32'd13, 64'd143, 1'b1, 20, "v5_pulse_busy", n_alu);
        run_op(32'd2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 2*W+2, "v5_start_at_done", n_alu);

        check("alu_reserved_never", 64'(alu11_seen), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
